instr_sequencer: RTL and testbench

Step sequencer that drives the instruction register's fetch/execute cycle. Generates the fetch control strobes (PC out, MAR load, RAM out, IR load, PC increment) for the active-low-load instruction register and presents the execute step number to the microcode decoder. Handles end-of-instruction, halt/resume and runaway-microcode overflow. Sits between the clock module and the microcode ROM/decoder in the control unit.

---
 rtl/cpu_ctrl_pkg.sv | 16 +
 rtl/step_counter.sv | 23 ++
 rtl/instr_sequencer.sv | 121 ++++++++++++
 tb/tb_instr_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared control-unit types and constants for the instruction sequencer
package cpu_ctrl_pkg;

  // Sequencer phases; the encoding is fixed so waveform dumps stay readable across revisions
  typedef enum logic [1:0] {
    FETCH_A = 2'd0,
    FETCH_B = 2'd1,
    EXEC    = 2'd2,
    HALTED  = 2'd3
  } seq_state_t;

  // Fetch occupies steps 0..FETCH_STEPS-1; execute numbering starts right after it
  localparam int FETCH_STEPS     = 2;
  localparam int STEP_FIRST_EXEC = FETCH_STEPS;

endpackage

// File: rtl/step_counter.sv
// rtl/step_counter.sv - step counter with sync clear, increment and terminal-count flag
module step_counter #(
  parameter int STEP_BITS = 3
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 inc,
  output logic [STEP_BITS-1:0] count,
  output logic                 tc
);

  // Clear has priority so a reset or instruction boundary always lands on step 0
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign tc = &count;

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/execute step sequencer driving IR fetch strobes and microcode step
module instr_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int STEP_BITS = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 step_end,
  input  logic                 halt_req,
  input  logic                 resume,
  input  logic                 clr_ovf,
  output logic                 pc_outn,
  output logic                 mar_loadn,
  output logic                 ram_outn,
  output logic                 ir_loadn,
  output logic                 pc_inc,
  output logic [STEP_BITS-1:0] step,
  output logic                 exec_en,
  output logic                 halted,
  output logic                 step_ovf
);

  seq_state_t           state;
  seq_state_t           state_nxt;
  logic                 cnt_clear;
  logic                 cnt_inc;
  logic                 cnt_tc;
  logic                 ovf_set;
  logic [STEP_BITS-1:0] cnt;

  localparam logic [STEP_BITS-1:0] LAST_FETCH_STEP = STEP_BITS'(STEP_FIRST_EXEC - 1);

  step_counter #(
    .STEP_BITS(STEP_BITS)
  ) u_step_counter (
    .clk  (clk),
    .clear(cnt_clear),
    .inc  (cnt_inc),
    .count(cnt),
    .tc   (cnt_tc)
  );

  // Next-state and counter control; halt is only honoured at the step_end boundary
  always_comb begin
    state_nxt = state;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    ovf_set   = 1'b0;
    case (state)
      FETCH_A: begin
        state_nxt = FETCH_B;
        cnt_inc   = 1'b1;
      end
      FETCH_B: begin
        cnt_inc = 1'b1;
        if (cnt == LAST_FETCH_STEP) begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (step_end) begin
          cnt_clear = 1'b1;
          state_nxt = halt_req ? HALTED : FETCH_A;
        end else if (cnt_tc) begin
          // Runaway microcode: force a new fetch rather than wrapping into fetch steps
          cnt_clear = 1'b1;
          ovf_set   = 1'b1;
          state_nxt = FETCH_A;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      HALTED: begin
        cnt_clear = 1'b1;
        if (resume) begin
          state_nxt = FETCH_A;
        end
      end
      default: begin
        cnt_clear = 1'b1;
        state_nxt = FETCH_A;
      end
    endcase
    if (reset) begin
      state_nxt = FETCH_A;
      cnt_clear = 1'b1;
      cnt_inc   = 1'b0;
      ovf_set   = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    state <= state_nxt;
  end

  // Sticky overflow flag; a new overflow beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      step_ovf <= 1'b0;
    end else if (ovf_set) begin
      step_ovf <= 1'b1;
    end else if (clr_ovf) begin
      step_ovf <= 1'b0;
    end
  end

  // Moore output decode from registered state only
  always_comb begin
    pc_outn   = (state != FETCH_A);
    mar_loadn = (state != FETCH_A);
    ram_outn  = (state != FETCH_B);
    ir_loadn  = (state != FETCH_B);
    pc_inc    = (state == FETCH_B);
    exec_en   = (state == EXEC);
    halted    = (state == HALTED);
    step      = cnt;
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - table-driven self-checking bench for instr_sequencer
module tb_instr_sequencer;

  logic       clk;
  logic       reset;
  logic       step_end;
  logic       halt_req;
  logic       resume;
  logic       clr_ovf;
  logic       pc_outn;
  logic       mar_loadn;
  logic       ram_outn;
  logic       ir_loadn;
  logic       pc_inc;
  logic [2:0] step;
  logic       exec_en;
  logic       halted;
  logic       step_ovf;

  int n_checks;
  int n_fail;

  // {pc_outn, mar_loadn, ram_outn, ir_loadn, pc_inc, exec_en, halted}
  localparam logic [6:0] O_FA = 7'b0011000;
  localparam logic [6:0] O_FB = 7'b1100100;
  localparam logic [6:0] O_EX = 7'b1111010;
  localparam logic [6:0] O_HT = 7'b1111001;

  typedef struct {
    logic       rst;
    logic       se;
    logic       hr;
    logic       rs;
    logic       co;
    logic       chk;
    logic [2:0] stp;
    logic [6:0] outs;
    logic       ovf;
  } vec_t;

  vec_t vq[$];

  instr_sequencer #(
    .STEP_BITS(3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .step_end (step_end),
    .halt_req (halt_req),
    .resume   (resume),
    .clr_ovf  (clr_ovf),
    .pc_outn  (pc_outn),
    .mar_loadn(mar_loadn),
    .ram_outn (ram_outn),
    .ir_loadn (ir_loadn),
    .pc_inc   (pc_inc),
    .step     (step),
    .exec_en  (exec_en),
    .halted   (halted),
    .step_ovf (step_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Row: inputs applied this cycle, outputs expected this cycle (before the edge)
  task automatic add(input logic rst, input logic se, input logic hr, input logic rs,
                     input logic co, input logic [2:0] stp, input logic [6:0] outs,
                     input logic ovf);
    vec_t v;
    v.rst = rst; v.se = se; v.hr = hr; v.rs = rs; v.co = co;
    v.chk = 1'b1; v.stp = stp; v.outs = outs; v.ovf = ovf;
    vq.push_back(v);
  endtask

  task automatic check_outs(input string name, input logic [2:0] exp_stp,
                            input logic [6:0] exp_outs, input logic exp_ovf);
    logic [6:0] act;
    act = {pc_outn, mar_loadn, ram_outn, ir_loadn, pc_inc, exec_en, halted};
    n_checks++;
    if (step !== exp_stp) begin
      n_fail++;
      $display("FAIL %s step: got %0d expected %0d", name, step, exp_stp);
    end
    n_checks++;
    if (act !== exp_outs || step_ovf !== exp_ovf) begin
      n_fail++;
      $display("FAIL %s outputs: got %b ovf=%b expected %b ovf=%b",
               name, act, step_ovf, exp_outs, exp_ovf);
    end
  endtask

  initial begin
    vec_t v0;
    int   cycles;
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1; step_end = 1'b0; halt_req = 1'b0; resume = 1'b0; clr_ovf = 1'b0;

    // Initial reset row, outputs unknown beforehand
    v0.rst = 1; v0.se = 0; v0.hr = 0; v0.rs = 0; v0.co = 0; v0.chk = 0;
    v0.stp = 0; v0.outs = O_FA; v0.ovf = 0;
    vq.push_back(v0);

    // Idle, step_end never asserted: 0..7 then forced wrap with overflow
    add(0,0,0,0,0, 3'd0, O_FA, 0);
    add(0,0,0,0,0, 3'd1, O_FB, 0);
    for (int s = 2; s <= 7; s++) add(0,0,0,0,0, 3'(s), O_EX, 0);
    add(0,0,0,0,1, 3'd0, O_FA, 1);
    add(0,0,0,0,0, 3'd1, O_FB, 0);
    // 4-cycle instructions ending at step 3; step_end ignored in FETCH_A
    add(0,0,0,0,0, 3'd2, O_EX, 0);
    add(0,1,0,0,0, 3'd3, O_EX, 0);
    add(0,0,0,0,0, 3'd0, O_FA, 0);
    add(0,0,0,0,0, 3'd1, O_FB, 0);
    add(0,0,0,0,0, 3'd2, O_EX, 0);
    add(0,1,0,0,0, 3'd3, O_EX, 0);
    add(0,1,0,0,0, 3'd0, O_FA, 0);
    // halt_req raised at step 1: instruction completes, then HALTED
    add(0,0,1,0,0, 3'd1, O_FB, 0);
    add(0,0,1,0,0, 3'd2, O_EX, 0);
    add(0,1,1,0,0, 3'd3, O_EX, 0);
    add(0,1,1,0,0, 3'd0, O_HT, 0);
    add(0,0,0,1,0, 3'd0, O_HT, 0);
    add(0,0,0,0,0, 3'd0, O_FA, 0);
    add(0,0,0,0,0, 3'd1, O_FB, 0);
    add(0,1,1,0,0, 3'd2, O_EX, 0);
    // halt_req and resume both held: one instruction then re-halt
    add(0,0,1,1,0, 3'd0, O_HT, 0);
    add(0,0,1,1,0, 3'd0, O_FA, 0);
    add(0,0,1,1,0, 3'd1, O_FB, 0);
    add(0,1,1,1,0, 3'd2, O_EX, 0);
    add(0,0,1,0,0, 3'd0, O_HT, 0);
    add(0,0,0,1,0, 3'd0, O_HT, 0);
    // Reset in FETCH_B, at step 5, and in HALTED
    add(0,0,0,0,0, 3'd0, O_FA, 0);
    add(1,0,0,0,0, 3'd1, O_FB, 0);
    add(0,0,0,0,0, 3'd0, O_FA, 0);
    add(0,0,0,0,0, 3'd1, O_FB, 0);
    for (int s = 2; s <= 4; s++) add(0,0,0,0,0, 3'(s), O_EX, 0);
    add(1,0,1,1,1, 3'd5, O_EX, 0);
    add(0,0,0,0,0, 3'd0, O_FA, 0);
    add(0,0,0,0,0, 3'd1, O_FB, 0);
    add(0,1,1,0,0, 3'd2, O_EX, 0);
    add(1,0,0,1,0, 3'd0, O_HT, 0);
    // Overflow with clr_ovf in the same cycle: set wins; clear takes effect later
    add(0,0,0,0,0, 3'd0, O_FA, 0);
    add(0,0,0,0,0, 3'd1, O_FB, 0);
    for (int s = 2; s <= 6; s++) add(0,0,0,0,0, 3'(s), O_EX, 0);
    add(0,0,0,0,1, 3'd7, O_EX, 0);
    add(0,0,0,0,0, 3'd0, O_FA, 1);
    add(0,0,0,0,1, 3'd1, O_FB, 1);
    add(0,1,0,0,0, 3'd2, O_EX, 0);
    add(0,0,0,0,0, 3'd0, O_FA, 0);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      reset    = vq[i].rst;
      step_end = vq[i].se;
      halt_req = vq[i].hr;
      resume   = vq[i].rs;
      clr_ovf  = vq[i].co;
      if (vq[i].chk) check_outs($sformatf("row%0d", i), vq[i].stp, vq[i].outs, vq[i].ovf);
    end

    // Halt latency from reset with step_end and halt_req held: FETCH_A, FETCH_B, EXEC, then HALTED
    @(negedge clk);
    reset = 1'b1; step_end = 1'b0; halt_req = 1'b0; resume = 1'b0; clr_ovf = 1'b0;
    @(negedge clk);
    reset = 1'b0; step_end = 1'b1; halt_req = 1'b1;
    cycles = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      cycles++;
      if (halted === 1'b1) break;
    end
    n_checks++;
    if (halted !== 1'b1 || cycles != 3) begin
      n_fail++;
      $display("FAIL halt_latency: got %0d cycles halted=%b expected 3 cycles halted=1",
               cycles, halted);
    end
    check_outs("halted_idle", 3'd0, O_HT, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
